// File: rtl/cpu_bus_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_bus_responder_if : CPU-side and external-side bus bundle        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface cpu_bus_responder_if;
   logic [15:0] cpu_addr;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ready;
   logic        ext_req;
   logic        ext_we;
   logic [15:0] ext_addr;
   logic [7:0]  ext_wdata;
   logic [7:0]  ext_rdata;
   logic        ext_ack;
   logic [7:0]  ie_reg;
   logic        bus_err;

   modport master (
      output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ext_rdata, ext_ack,
      input  cpu_rdata, cpu_ready, ext_req, ext_we, ext_addr, ext_wdata,
             ie_reg, bus_err
   );

   modport slave (
      input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ext_rdata, ext_ack,
      output cpu_rdata, cpu_ready, ext_req, ext_we, ext_addr, ext_wdata,
             ie_reg, bus_err
   );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_bus_responder : HRAM/IE responder with external bus forwarding  |
// | Optional macro BUS_TIMEOUT_EN adds an EXT_WAIT abort timer.         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module cpu_bus_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input wire             clk,
   input wire             rst,
   cpu_bus_responder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_INT_RSP  = 2'd1,
      S_EXT_WAIT = 2'd2,
      S_EXT_RSP  = 2'd3
   } state_t;

   state_t      state_q;
   logic [7:0]  hram_q [0:126];
   logic [7:0]  rdata_q;
   logic        ready_q;
   logic        err_q;
   logic [7:0]  ie_q;
   logic        ext_req_q;
   logic        ext_we_q;
   logic [15:0] ext_addr_q;
   logic [7:0]  ext_wdata_q;

   logic        req_d;
   logic        sel_int_d;
   logic        sel_ie_d;
   logic [6:0]  hram_idx_d;
   logic        hram_we_d;

   // 0xFF80..0xFFFF share the top nine address bits; 0xFFFF is IE
   assign req_d      = bus.cpu_rd | bus.cpu_wr;
   assign sel_int_d  = (bus.cpu_addr[15:7] == 9'h1FF);
   assign sel_ie_d   = (bus.cpu_addr == 16'hFFFF);
   assign hram_idx_d = bus.cpu_addr[6:0];
   assign hram_we_d  = rst && (state_q == S_IDLE) && bus.cpu_wr && sel_int_d && !sel_ie_d;

   // HRAM deliberately has no reset so its contents survive rst
   always_ff @(posedge clk) begin
      if (hram_we_d) begin
         hram_q[hram_idx_d] <= bus.cpu_wdata;
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_q;
`else
   generate
      if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
      end
   endgenerate
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         rdata_q     <= 8'h00;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         ie_q        <= 8'h00;
         ext_req_q   <= 1'b0;
         ext_we_q    <= 1'b0;
         ext_addr_q  <= 16'h0000;
         ext_wdata_q <= 8'h00;
`ifdef BUS_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_d) begin
                  // simultaneous rd+wr is serviced as a write and flagged
                  err_q <= bus.cpu_rd & bus.cpu_wr;
                  if (sel_int_d) begin
                     ready_q <= 1'b1;
                     state_q <= S_INT_RSP;
                     if (bus.cpu_wr) begin
                        if (sel_ie_d) ie_q <= bus.cpu_wdata;
                     end else begin
                        rdata_q <= sel_ie_d ? ie_q : hram_q[hram_idx_d];
                     end
                  end else begin
                     ext_req_q   <= 1'b1;
                     ext_we_q    <= bus.cpu_wr;
                     ext_addr_q  <= bus.cpu_addr;
                     ext_wdata_q <= bus.cpu_wdata;
                     state_q     <= S_EXT_WAIT;
`ifdef BUS_TIMEOUT_EN
                     to_cnt_q    <= '0;
`endif
                  end
               end
            end
            S_EXT_WAIT: begin
               if (bus.ext_ack) begin
                  ext_req_q <= 1'b0;
                  ready_q   <= 1'b1;
                  state_q   <= S_EXT_RSP;
                  if (!ext_we_q) rdata_q <= bus.ext_rdata;
               end
`ifdef BUS_TIMEOUT_EN
               else if (to_cnt_q == TO_LAST) begin
                  ext_req_q <= 1'b0;
                  ready_q   <= 1'b1;
                  err_q     <= 1'b1;
                  state_q   <= S_EXT_RSP;
                  if (!ext_we_q) rdata_q <= 8'hFF;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
`endif
            end
            S_INT_RSP, S_EXT_RSP: state_q <= S_IDLE;
            default:              state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_ready = ready_q;
   assign bus.bus_err   = err_q;
   assign bus.ie_reg    = ie_q;
   assign bus.ext_req   = ext_req_q;
   assign bus.ext_we    = ext_we_q;
   assign bus.ext_addr  = ext_addr_q;
   assign bus.ext_wdata = ext_wdata_q;

endmodule
`default_nettype wire

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: EXT_WAIT cycles allowed before abort (used only with BUS_TIMEOUT_EN).
REQ-002 SHALL have clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have cpu_addr  input  16  address of the current CPU memory step.
REQ-005 SHALL have cpu_rd  input  1  CPU read request.
REQ-006 SHALL have cpu_wr  input  1  CPU write request.
REQ-007 SHALL have cpu_wdata  input  8  CPU write data.
REQ-008 SHALL have cpu_rdata  output  8  registered read data, valid when cpu_ready=1.
REQ-009 SHALL have cpu_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have ext_req, ext_we  output  1 each  external request and write-enable.
REQ-011 SHALL have ext_addr  output  16, ext_wdata  output  8  external address/data, registered.
REQ-012 SHALL have ext_rdata  input  8, ext_ack  input  1  external read data and acknowledge.
REQ-013 SHALL have ie_reg  output  8  interrupt-enable register (address 0xFFFF).
REQ-014 SHALL have bus_err  output  1  one-cycle error pulse.

Function
REQ-015 SHALL implement states IDLE, INT_RSP, EXT_WAIT, EXT_RSP; requests are sampled only in IDLE.
REQ-016 Address decode: 0xFF80-0xFFFE = HRAM (127 x 8 internal array, index addr-0xFF80); 0xFFFF = IE; all else = external.
REQ-017 IDLE with request to HRAM/IE at cycle N SHALL perform the access at N and enter INT_RSP; cpu_ready=1 at N+1 with cpu_rdata = stored byte (read) or unchanged (write).
REQ-018 A write to HRAM/IE SHALL update storage at the sampling edge; ie_reg reflects the new value from N+1.
REQ-019 IDLE with external request at cycle N SHALL register ext_addr, ext_wdata, ext_we, set ext_req=1 from N+1 and enter EXT_WAIT.
REQ-020 In EXT_WAIT ext_req, ext_addr, ext_we, ext_wdata SHALL stay stable until ext_ack is sampled 1.
REQ-021 On ext_ack=1 sampled at cycle M SHALL drop ext_req, capture ext_rdata (read) into cpu_rdata, enter EXT_RSP; cpu_ready=1 at M+1.
REQ-022 ext_ack while not in EXT_WAIT SHALL be ignored.
REQ-023 INT_RSP and EXT_RSP SHALL last one cycle, then return to IDLE.
REQ-024 The initiator SHALL present a new request or none on the cycle after cpu_ready; the responder services whatever IDLE samples.
REQ-025 cpu_rd and cpu_wr both 1 in IDLE SHALL be serviced as a write and pulse bus_err for one cycle at N+1.
REQ-026 cpu_rdata SHALL hold its last value when cpu_ready=0; write completions leave it unchanged.

Reset
REQ-027 rst=0 at a clock edge SHALL force IDLE, cpu_rdata=0x00, cpu_ready=0, ext_req=0, ext_we=0, ext_addr=0x0000, ext_wdata=0x00, ie_reg=0x00, bus_err=0, timeout counter=0.
REQ-028 Reset mid-transaction SHALL abort it with no cpu_ready pulse; HRAM contents SHALL NOT be cleared.

Configuration
REQ-029 Macro BUS_TIMEOUT_EN defined: counter increments each EXT_WAIT cycle; after TIMEOUT_CYCLES cycles without ack SHALL drop ext_req, set cpu_rdata=0xFF (reads), pulse cpu_ready and bus_err together next cycle, return to IDLE.
REQ-030 With BUS_TIMEOUT_EN, ack sampled on the expiry cycle SHALL win (normal completion, no bus_err).
REQ-031 BUS_TIMEOUT_EN undefined: no counter; EXT_WAIT waits indefinitely; bus_err only from REQ-025.

Verification
REQ-032 Write 0x5A to 0xFF80, then read 0xFF80 -> cpu_ready one cycle after each request, read cpu_rdata=0x5A.
REQ-033 Write 0x1F to 0xFFFF -> ie_reg=0x1F next cycle; rst=0 -> ie_reg=0x00, HRAM 0xFF80 still reads 0x5A.
REQ-034 Read 0xC000, ext_ack after 3 wait cycles with ext_rdata=0x77 -> ext_req high 3 cycles, ext_addr=0xC000 stable, cpu_ready one cycle after ack, cpu_rdata=0x77.
REQ-035 cpu_rd=cpu_wr=1 to 0xFF81 data 0x33 -> bus_err pulse, later read of 0xFF81 returns 0x33.
REQ-036 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, read 0x8000, no ack -> ext_req drops, cpu_ready and bus_err pulse, cpu_rdata=0xFF; repeat with ack on 4th cycle -> no bus_err.
REQ-037 rst=0 during EXT_WAIT -> ext_req=0 next cycle, no cpu_ready, IDLE accepts next request.
